// File: rtl/axis_pkg.sv
// Shared AXI-Stream constants.
//   AXIS_BYTE_W       : width of one AXIS byte lane
//   OUT_BYTES_DEFAULT : default output beat width in bytes for stream upsizers
package axis_pkg;

  localparam int unsigned AXIS_BYTE_W       = 8;
  localparam int unsigned OUT_BYTES_DEFAULT = 4;

endpackage : axis_pkg

// File: rtl/axis_upsizer_8to32.sv
// Byte-to-beat AXI-Stream upsizer: packs accepted input bytes into
// OUT_BYTES-wide output beats, closing a beat early on s_axis_last so that
// packets never share a beat. Counts emitted packets.
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   s_axis_data     : input byte
//   s_axis_valid    : input byte valid
//   s_axis_last     : final byte of a packet
//   s_axis_ready    : combinational; high when the output register is free
//                     or being drained this cycle
//   m_axis_data     : packed output beat, byte 0 in bits [7:0]
//   m_axis_keep     : per-lane valid mask (unused lanes read as zero)
//   m_axis_valid    : output beat valid
//   m_axis_last     : beat carries the final byte of a packet
//   m_axis_ready    : downstream accepts the beat
//   pkt_count       : number of last-beats accepted downstream, wraps at 16 bits
module axis_upsizer_8to32
  import axis_pkg::*;
#(
  parameter int unsigned OUT_BYTES = OUT_BYTES_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [AXIS_BYTE_W-1:0]             s_axis_data,
  input  logic                               s_axis_valid,
  input  logic                               s_axis_last,
  output logic                               s_axis_ready,
  output logic [AXIS_BYTE_W*OUT_BYTES-1:0]   m_axis_data,
  output logic [OUT_BYTES-1:0]               m_axis_keep,
  output logic                               m_axis_valid,
  output logic                               m_axis_last,
  input  logic                               m_axis_ready,
  output logic [15:0]                        pkt_count
);

  localparam int unsigned DATA_W    = AXIS_BYTE_W * OUT_BYTES;
  localparam int unsigned IDX_W     = $clog2(OUT_BYTES);
  localparam int unsigned LAST_LANE = OUT_BYTES - 1;

  logic [IDX_W-1:0]     idx;
  logic [DATA_W-1:0]    acc;

  logic                 in_fire_c;
  logic                 out_fire_c;
  logic                 beat_done_c;
  logic [DATA_W-1:0]    acc_merged_c;
  logic [OUT_BYTES-1:0] keep_next_c;

  // Only stall source is a full output register that is not being drained.
  assign s_axis_ready = !m_axis_valid || m_axis_ready;

  assign in_fire_c   = s_axis_valid && s_axis_ready;
  assign out_fire_c  = m_axis_valid && m_axis_ready;
  assign beat_done_c = in_fire_c && ((idx == IDX_W'(LAST_LANE)) || s_axis_last);

  // Accumulator with the current byte dropped into lane idx; lanes above idx
  // are still zero because the accumulator is cleared at every beat boundary.
  always_comb begin
    acc_merged_c = acc;
    keep_next_c  = '0;
    for (int unsigned i = 0; i < OUT_BYTES; i++) begin
      if (IDX_W'(i) == idx) begin
        acc_merged_c[i*AXIS_BYTE_W +: AXIS_BYTE_W] = s_axis_data;
      end
      keep_next_c[i] = (IDX_W'(i) <= idx);
    end
  end

  // Lane counter and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      acc <= '0;
    end else if (in_fire_c) begin
      if (beat_done_c) begin
        idx <= '0;
        acc <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
        acc <= acc_merged_c;
      end
    end
  end

  // Output register: a completing beat overrides the drain so that a
  // simultaneous accept-and-reload leaves no bubble. Payload holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_keep  <= '0;
      m_axis_last  <= 1'b0;
    end else begin
      if (out_fire_c) begin
        m_axis_valid <= 1'b0;
      end
      if (beat_done_c) begin
        m_axis_valid <= 1'b1;
        m_axis_data  <= acc_merged_c;
        m_axis_keep  <= keep_next_c;
        m_axis_last  <= s_axis_last;
      end
    end
  end

  // Packet counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (out_fire_c && m_axis_last) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule : axis_upsizer_8to32

// File: tb/tb_axis_upsizer_8to32.sv
// Self-checking bench for axis_upsizer_8to32 (OUT_BYTES = 4): a byte-queue
// reference model tracks the expected output register and packet count; the
// outputs are compared against it every cycle, and directed scenarios pin the
// model with literal beats.
module tb_axis_upsizer_8to32;

  localparam int unsigned OB = 4;
  localparam int unsigned DW = 8 * OB;

  typedef struct {
    logic [DW-1:0] data;
    logic [OB-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_axis_data = '0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_last = 1'b0;
  logic          s_axis_ready;
  logic [DW-1:0] m_axis_data;
  logic [OB-1:0] m_axis_keep;
  logic          m_axis_valid;
  logic          m_axis_last;
  logic          m_axis_ready = 1'b1;
  logic [15:0]   pkt_count;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 0;     // 0: always ready, 1: never ready, 2: random
  bit started  = 1'b0;

  axis_upsizer_8to32 #(.OUT_BYTES(OB)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_keep  (m_axis_keep),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  // Downstream ready driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_ready = 1'b1;
      1:       m_axis_ready = 1'b0;
      default: m_axis_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference model state.
  logic [7:0]    pend_q[$];
  beat_t         emit_q[$];
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_data  = '0;
  logic [OB-1:0] exp_keep  = '0;
  logic          exp_last  = 1'b0;
  logic [15:0]   exp_cnt   = '0;

  always @(posedge clk) begin
    bit            rdy;
    int            n;
    beat_t         b;
    rdy = !exp_valid || m_axis_ready;
    if (rst) begin
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_keep  = '0;
      exp_last  = 1'b0;
      exp_cnt   = '0;
      pend_q.delete();
    end else begin
      if (exp_valid && m_axis_ready) begin
        if (exp_last) exp_cnt = exp_cnt + 16'd1;
        exp_valid = 1'b0;
      end
      if (s_axis_valid && rdy) begin
        pend_q.push_back(s_axis_data);
        if (pend_q.size() == OB || s_axis_last) begin
          n = pend_q.size();
          b.data = '0;
          for (int i = 0; i < n; i++) b.data[i*8 +: 8] = pend_q[i];
          b.keep = OB'((1 << n) - 1);
          b.last = s_axis_last;
          exp_data  = b.data;
          exp_keep  = b.keep;
          exp_last  = b.last;
          exp_valid = 1'b1;
          emit_q.push_back(b);
          pend_q.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("s_axis_ready", 64'(s_axis_ready), 64'(!exp_valid || m_axis_ready));
      chk("m_axis_valid", 64'(m_axis_valid), 64'(exp_valid));
      chk("m_axis_data",  64'(m_axis_data),  64'(exp_data));
      chk("m_axis_keep",  64'(m_axis_keep),  64'(exp_keep));
      chk("m_axis_last",  64'(m_axis_last),  64'(exp_last));
      chk("pkt_count",    64'(pkt_count),    64'(exp_cnt));
    end
  end

  // All tasks enter and leave at posedge + 2.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle();
    s_axis_valid = 1'b0;
    s_axis_data  = 8'($urandom);
    s_axis_last  = 1'($urandom);
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit acc;
    int waited;
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = l;
    acc    = 1'b0;
    waited = 0;
    while (!acc) begin
      @(negedge clk);
      acc = s_axis_ready;
      tick(1);
      waited++;
      if (!acc && waited > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: byte 0x%0h never accepted", d);
        acc = 1'b1;
      end
    end
    s_axis_valid = 1'b0;
  endtask

  task automatic chk_beat(input string name, input int i, input logic [DW-1:0] d,
                          input logic [OB-1:0] k, input logic l);
    if (i >= emit_q.size()) begin
      chk({name, "_present"}, 64'(emit_q.size()), 64'(i + 1));
    end else begin
      chk({name, "_data"}, 64'(emit_q[i].data), 64'(d));
      chk({name, "_keep"}, 64'(emit_q[i].keep), 64'(k));
      chk({name, "_last"}, 64'(emit_q[i].last), 64'(l));
    end
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    started = 1'b1;
    chk("reset_pkt_count", 64'(pkt_count), 64'h0);
    chk("reset_valid",     64'(m_axis_valid), 64'h0);
    rst = 1'b0;
    tick(1);

    // Four-byte packet.
    emit_q.delete();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
    tick(2);
    chk("t4_beats", 64'(emit_q.size()), 64'd1);
    chk_beat("t4", 0, 32'h44332211, 4'hF, 1'b1);
    chk("t4_pkt_count", 64'(pkt_count), 64'd1);

    // Six-byte packet spanning two beats.
    emit_q.delete();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA1 + i), (i == 5));
    tick(2);
    chk("t6_beats", 64'(emit_q.size()), 64'd2);
    chk_beat("t6_b1", 0, 32'hA4A3A2A1, 4'hF, 1'b0);
    chk_beat("t6_b2", 1, 32'h0000A6A5, 4'h3, 1'b1);

    // One-byte packet.
    emit_q.delete();
    send_byte(8'h5A, 1'b1);
    tick(2);
    chk_beat("t1", 0, 32'h0000005A, 4'h1, 1'b1);
    chk("t1_pkt_count", 64'(pkt_count), 64'd3);

    // Backpressure hold for five cycles, then release.
    emit_q.delete();
    rdy_mode = 1;
    tick(1);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    s_axis_valid = 1'b1;
    s_axis_data  = 8'h55;
    s_axis_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_s_ready", 64'(s_axis_ready), 64'h0);
      chk("hold_data",    64'(m_axis_data),  64'h44332211);
      chk("hold_valid",   64'(m_axis_valid), 64'h1);
      tick(1);
    end
    rdy_mode = 0;
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b1);
    tick(2);
    chk_beat("hold_b1", 0, 32'h44332211, 4'hF, 1'b0);
    chk_beat("hold_b2", 1, 32'h88776655, 4'hF, 1'b1);

    // Reset mid-packet drops the partial beat.
    emit_q.delete();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    rst = 1'b1;
    tick(1);
    chk("midrst_pkt_count", 64'(pkt_count), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h03 + i), (i == 3));
    tick(2);
    chk("midrst_beats", 64'(emit_q.size()), 64'd1);
    chk_beat("midrst", 0, 32'h06050403, 4'hF, 1'b1);

    // Randomized traffic with idle gaps and random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send_byte(8'($urandom), ($urandom_range(0, 5) == 0));
    end
    rdy_mode = 0;
    idle();
    tick(4);

    // Counter wrap with 65536 one-byte packets.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 65536; i++) send_byte(8'($urandom), 1'b1);
    tick(3);
    chk("wrap_pkt_count", 64'(pkt_count), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_axis_upsizer_8to32

// File: doc/axis_upsizer_8to32.md
AXIS_UPSIZER_8TO32 -- requirements
Module: axis_upsizer_8to32

Interface
REQ-001 Parameter: OUT_BYTES, default 4, output beat width in bytes; legal range 2..8.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_axis_data  input  8  input byte.
REQ-005 s_axis_valid  input  1  input byte valid.
REQ-006 s_axis_last  input  1  marks the final byte of a packet.
REQ-007 s_axis_ready  output  1  block accepts the input byte this cycle.
REQ-008 m_axis_data  output  8*OUT_BYTES  packed output beat; byte 0 in bits [7:0].
REQ-009 m_axis_keep  output  OUT_BYTES  per-lane valid mask.
REQ-010 m_axis_valid  output  1  output beat valid.
REQ-011 m_axis_last  output  1  beat holds the final byte of a packet.
REQ-012 m_axis_ready  input  1  downstream accepts the beat.
REQ-013 pkt_count  output  16  count of packets emitted (beats with m_axis_last=1 accepted).

Function
REQ-014 Input transfer occurs when s_axis_valid=1 and s_axis_ready=1; output transfer occurs when m_axis_valid=1 and m_axis_ready=1.
REQ-015 s_axis_ready shall be !m_axis_valid | m_axis_ready, combinational; there is no other stall source.
REQ-016 Lane index idx (0..OUT_BYTES-1) shall select the accumulator lane written by each accepted byte, then increment by 1.
REQ-017 A beat completes on the accepted byte where idx=OUT_BYTES-1 or s_axis_last=1.
REQ-018 On beat completion, on the next edge: the output register loads the accumulator plus the current byte; m_axis_keep = lanes 0..idx set; m_axis_last = s_axis_last; m_axis_valid = 1; idx = 0; accumulator cleared.
REQ-019 Lanes not covered by m_axis_keep shall read as 0 in m_axis_data.
REQ-020 Latency: m_axis_valid rises on the cycle after the completing byte is accepted.
REQ-021 m_axis_data, m_axis_keep and m_axis_last shall hold stable while m_axis_valid=1 and m_axis_ready=0.
REQ-022 If a beat is accepted downstream and no new beat completes in the same cycle, m_axis_valid shall clear on the next edge.
REQ-023 Simultaneous output accept and new beat completion shall reload the output register with no bubble; sustained throughput is one byte per cycle.
REQ-024 A one-byte packet (s_axis_last on lane 0) shall emit keep=0b0001 (for OUT_BYTES=4) and last=1.
REQ-025 Back-to-back packets shall never share a beat; the first byte after a last shall always occupy lane 0.
REQ-026 pkt_count shall increment by 1 per accepted beat with m_axis_last=1, wrapping 0xFFFF -> 0x0000.
REQ-027 Inputs while s_axis_valid=0 shall have no effect on state.

Reset
REQ-028 While rst=1 on an edge: m_axis_valid=0, m_axis_data=0, m_axis_keep=0, m_axis_last=0, idx=0, accumulator=0, pkt_count=0.
REQ-029 During rst=1, s_axis_ready follows REQ-015 but accepted bytes are discarded.
REQ-030 Reset mid-packet shall drop the partial beat and any pending output beat; the next accepted byte lands in lane 0.

Structure
REQ-031 A shared package axis_pkg shall hold the AXIS byte-width constant (8) and the default OUT_BYTES.
REQ-032 The block shall be a single module with no sub-module; the accumulator, lane counter and output register are inline.

Verification
REQ-033 Bytes 0x11,0x22,0x33,0x44 (last on 0x44), m_axis_ready=1 -> one beat: data=0x44332211, keep=0xF, last=1, pkt_count=1.
REQ-034 Bytes 0xA1..0xA6 (last on 0xA6) -> beat1 data=0xA4A3A2A1 keep=0xF last=0; beat2 data=0x0000A6A5 keep=0x3 last=1.
REQ-035 Single byte 0x5A with last -> data=0x0000005A, keep=0x1, last=1.
REQ-036 Hold m_axis_ready=0 with a beat pending for 5 cycles -> s_axis_ready=0, output stable; release -> beat accepted, streaming resumes with no lost byte.
REQ-037 Assert rst after 2 bytes 0x01,0x02, then send 0x03..0x06 with last -> single beat 0x06050403, keep=0xF.
REQ-038 Send 65536 one-byte packets -> pkt_count wraps to 0x0000.
